sisc_fetch: RTL

- Instruction-fetch and program-counter stage of the SISC CPU; sits directly upstream of the control FSM.
- Holds PC and IR and fetches instructions from instruction memory over a req/ack handshake.
- Presents the opcode and mm fields to the control FSM.
- Consumes the FSM's ir_load, pc_write, pc_sel, br_sel and pc_rst, plus the ALU status flags, to sequence and branch the PC.

---
 rtl/sisc_fetch.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sisc_fetch.sv
// SISC instruction-fetch / program-counter stage: owns PC and IR, fetches over a
// req/ack memory handshake and resolves conditional branches from ALU flags.
module sisc_fetch #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               ir_load,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               pc_rst,
  input  logic [3:0]         stat,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               ir_valid,
  output logic               busy,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VALID,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_BRA = 4'd4;
  localparam logic [3:0] OP_BRR = 4'd5;
  localparam logic [3:0] OP_BNE = 4'd6;
  localparam logic [3:0] OP_BNR = 4'd7;
  localparam logic [3:0] OP_HLT = 4'd15;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_ir;
  logic                 r_req;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_ir_valid;
  logic                 r_busy;
  logic                 r_halted;

  logic [3:0]           w_opcode;
  logic [3:0]           w_mm;
  logic [15:0]          w_imm;
  logic                 w_taken;
  logic [ADDR_W-1:0]    w_target;
  logic [ADDR_W-1:0]    w_pc_next;
  logic                 w_start;

  // BRA/BRR branch when any masked flag is set, BNE/BNR when none is.
  function automatic logic f_taken(input logic [3:0] op,
                                   input logic [3:0] flags,
                                   input logic [3:0] mask);
    logic hit;
    hit = |(flags & mask);
    case (op)
      OP_BRA, OP_BRR: f_taken = hit;
      OP_BNE, OP_BNR: f_taken = ~hit;
      default:        f_taken = 1'b0;
    endcase
  endfunction

  // Size casts give sign-extension for relative and zero-extension for
  // absolute targets; the add wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] f_target(input logic              rel,
                                                 input logic [ADDR_W-1:0] pc,
                                                 input logic [15:0]       imm);
    logic signed [15:0] imm_s;
    imm_s = signed'(imm);
    if (rel) f_target = pc + ADDR_W'(imm_s);
    else     f_target = ADDR_W'(imm);
  endfunction

  assign w_opcode = r_ir[31:28];
  assign w_mm     = r_ir[27:24];
  assign w_imm    = r_ir[15:0];
  assign w_taken  = f_taken(w_opcode, stat, w_mm);
  assign w_target = f_target(br_sel, r_pc, w_imm);

  always_comb begin
    w_pc_next = r_pc;
    if (pc_rst)                          w_pc_next = '0;
    else if (pc_write && pc_sel && w_taken) w_pc_next = w_target;
    else if (pc_write)                   w_pc_next = r_pc + ADDR_W'(1);
  end

  // A fetch may only be launched when no fetch is in flight and not halted.
  assign w_start = ir_load && ((r_state == S_IDLE) || (r_state == S_VALID));

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) r_pc <= '0;
    else       r_pc <= w_pc_next;
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      r_state    <= S_IDLE;
      r_ir       <= '0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_ir_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_VALID: begin
          if (w_start) begin
            r_addr     <= r_pc;
            r_req      <= 1'b1;
            r_busy     <= 1'b1;
            r_ir_valid <= 1'b0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            r_ir       <= imem_rdata;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_ir_valid <= 1'b1;
            if (imem_rdata[31:28] == OP_HLT) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_state  <= S_VALID;
            end
          end
        end
        S_HALT: begin
          r_halted   <= 1'b1;
          r_ir_valid <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign instr     = r_ir;
  assign opcode    = w_opcode;
  assign mm        = w_mm;
  assign pc_out    = r_pc;
  assign ir_valid  = r_ir_valid;
  assign busy      = r_busy;
  assign halted    = r_halted;

endmodule
